// File: rtl/rf_2r_1w_param.sv
`default_nettype none
// ============================================================================
//  Module   : rf_2r_1w_param
//  Purpose  : Parametrised register file with two combinational read ports,
//             one synchronous write port, a hardware clear sequencer that
//             zeroes every entry after reset or on request, and an optional
//             write-to-read bypass.
//  Ports    : rf_clock        - clock, all state changes on the rising edge
//             rf_reset        - asynchronous active-low reset (starts a sweep)
//             rf_clear        - synchronous request to zero all entries
//             rf_rd_addr_0/1  - read addresses
//             rf_rd_data_0/1  - read data (combinational, 0 while busy)
//             rf_wr_enable    - write request
//             rf_wr_addr      - write address
//             rf_wr_data      - write data
//             rf_wr_accepted  - write request taken this cycle
//             rf_busy         - clear sweep in progress
//  Revision : 1.0 - initial release
// ============================================================================
module rf_2r_1w_param #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 3,
    parameter int BYPASS    = 1
) (
    input  logic                 rf_clock,
    input  logic                 rf_reset,
    input  logic                 rf_clear,
    input  logic [ADDR_BITS-1:0] rf_rd_addr_0,
    output logic [WIDTH-1:0]     rf_rd_data_0,
    input  logic [ADDR_BITS-1:0] rf_rd_addr_1,
    output logic [WIDTH-1:0]     rf_rd_data_1,
    input  logic                 rf_wr_enable,
    input  logic [ADDR_BITS-1:0] rf_wr_addr,
    input  logic [WIDTH-1:0]     rf_wr_data,
    output logic                 rf_wr_accepted,
    output logic                 rf_busy
);

    localparam int DEPTH = 1 << ADDR_BITS;
    // Last entry of the sweep is the all-ones address (DEPTH-1).
    localparam logic [ADDR_BITS-1:0] C_LAST_ADDR = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_BITS-1:0] r_clr_addr;
    logic [ADDR_BITS-1:0] w_clr_addr_nxt;
    logic                 w_sweep_we;
    logic [ADDR_BITS-1:0] w_sweep_addr;
    logic                 w_fwd_0;
    logic                 w_fwd_1;

    // No reset on the storage so it can map onto distributed RAM.
    logic [WIDTH-1:0]     r_mem [DEPTH];

    assign rf_busy        = (r_state == ST_CLEAR);
    assign rf_wr_accepted = rf_wr_enable && !rf_busy;

    // ------------------------------------------------------------------
    // Clear sequencer: next state, next counter and sweep write port.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_sweep_we     = 1'b0;
        w_sweep_addr   = r_clr_addr;
        case (r_state)
            ST_IDLE: begin
                // The request edge itself writes nothing; the sweep starts
                // on the following edge.
                if (rf_clear) begin
                    w_state_nxt    = ST_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            ST_CLEAR: begin
                w_sweep_we = 1'b1;
                if (rf_clear) begin
                    // Restart: entry 0 is cleared on this edge, so the
                    // counter moves on to 1 and a full sweep follows.
                    w_sweep_addr   = '0;
                    w_clr_addr_nxt = ADDR_BITS'(1);
                end else if (r_clr_addr == C_LAST_ADDR) begin
                    w_state_nxt    = ST_IDLE;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + ADDR_BITS'(1);
                end
            end
            default: begin
                w_state_nxt    = ST_CLEAR;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge rf_clock or negedge rf_reset) begin
        if (!rf_reset) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Storage. Sweep and user writes are mutually exclusive because user
    // writes are only accepted outside the sweep.
    // ------------------------------------------------------------------
    always_ff @(posedge rf_clock) begin
        if (w_sweep_we) begin
            r_mem[w_sweep_addr] <= '0;
        end else if (rf_wr_accepted) begin
            r_mem[rf_wr_addr] <= rf_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read ports with optional same-cycle forwarding of accepted writes.
    // ------------------------------------------------------------------
    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_fwd_0 = rf_wr_accepted && (rf_wr_addr == rf_rd_addr_0);
            assign w_fwd_1 = rf_wr_accepted && (rf_wr_addr == rf_rd_addr_1);
        end else begin : g_no_bypass
            assign w_fwd_0 = 1'b0;
            assign w_fwd_1 = 1'b0;
        end
    endgenerate

    assign rf_rd_data_0 = rf_busy ? '0 : (w_fwd_0 ? rf_wr_data : r_mem[rf_rd_addr_0]);
    assign rf_rd_data_1 = rf_busy ? '0 : (w_fwd_1 ? rf_wr_data : r_mem[rf_rd_addr_1]);

endmodule
`default_nettype wire

// File: doc/rf_2r_1w_param.md
# rf_2r_1w_param

Parametrised two-read, one-write register file with a hardware clear sequencer and optional write-to-read bypass. It generalises the fixed 8x32 single-read file to any power-of-two depth and any word width, and replaces "contents undefined after reset" with a guaranteed all-zero state. It sits in datapath blocks (register banks, small lookup stores) that need two simultaneous operand reads and a known initial state.

## Interface

Parameters:
- WIDTH, 32, data word width in bits (>=1)
- ADDR_BITS, 3, address width; depth DEPTH = 2^ADDR_BITS (1..8)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port; 0 = reads see array only

Ports:
- rf_clock  input  1  clock; all state changes on rising edge
- rf_reset  input  1  asynchronous, active-low reset
- rf_clear  input  1  synchronous request to zero all entries
- rf_rd_addr_0  input  ADDR_BITS  read port 0 address
- rf_rd_data_0  output  WIDTH  read port 0 data (combinational)
- rf_rd_addr_1  input  ADDR_BITS  read port 1 address
- rf_rd_data_1  output  WIDTH  read port 1 data (combinational)
- rf_wr_enable  input  1  write request
- rf_wr_addr  input  ADDR_BITS  write address
- rf_wr_data  input  WIDTH  write data
- rf_wr_accepted  output  1  combinational: rf_wr_enable && !rf_busy
- rf_busy  output  1  clear sequence in progress

## Operation

- Storage: DEPTH x WIDTH array, no asynchronous reset on the array (must map to distributed RAM). Zeroing is done only by the clear sequencer.
- FSM states: IDLE, CLEAR. Clear counter clr_addr, ADDR_BITS wide.
- Reset (rf_reset low): state=CLEAR, clr_addr=0, rf_busy=1, asynchronously, held while low.
- CLEAR: each rising edge writes 0 to entry clr_addr; clr_addr increments. At clr_addr==DEPTH-1 the write occurs and state -> IDLE, clr_addr -> 0.
- CLEAR with rf_clear=1: clr_addr restarts at 0 (entry 0 cleared that edge, counter -> 1); sequence runs full DEPTH cycles from the restart.
- IDLE with rf_clear=1: state -> CLEAR, clr_addr=0; no array write that edge. User write on that same edge is accepted (rf_busy still 0) and then overwritten by the sweep.
- rf_busy = (state==CLEAR), registered.
- Writes: when rf_wr_accepted, rf_wr_data stored at rf_wr_addr on the edge. While rf_busy, writes are dropped, not queued; rf_wr_accepted=0.
- Reads: rf_rd_data_n = array[rf_rd_addr_n], combinational in address and array contents. While rf_busy both read outputs are forced to 0.
- Bypass (BYPASS=1): if rf_wr_accepted and rf_wr_addr==rf_rd_addr_n, rf_rd_data_n = rf_wr_data. Both ports may bypass simultaneously. BYPASS=0: read returns old contents until after the edge.
- Both read ports may address the same entry; no conflict.

## Timing

- Reset release: DEPTH rising edges of CLEAR; rf_busy falls after the DEPTH-th edge. First accepted write possible in the cycle following that edge.
- Clear request in IDLE: rf_busy high after the requesting edge; low DEPTH edges later (total DEPTH+1 edges including the request edge).
- Write latency: 1 edge to array; 0 cycles to read port with BYPASS=1.
- Reset mid-sweep: asynchronous restart to clr_addr=0, full DEPTH-cycle sweep.
- ADDR_BITS=1..8 all legal; counter wrap from DEPTH-1 to 0 coincides with IDLE entry.

## Test plan

- Reset, WIDTH=32 ADDR_BITS=3: release reset -> rf_busy=1 for exactly 8 edges, reads 0 throughout; then all 8 entries read 0x00000000 on both ports.
- Write 0xDEADBEEF to addr 5, 0x12345678 to addr 2 after idle -> next cycle port 0 addr 5 = 0xDEADBEEF, port 1 addr 2 = 0x12345678 simultaneously.
- BYPASS=1: write 0xCAFEF00D to addr 3 with both read addrs=3 same cycle -> both outputs 0xCAFEF00D before the edge; BYPASS=0 -> old value (0) before edge, new after.
- Write during busy: rf_wr_enable=1 addr 1 data 0xFFFFFFFF during sweep -> rf_wr_accepted=0, after sweep addr 1 reads 0.
- rf_clear in IDLE after filling all entries with 0xA5A5A5A5 -> rf_busy high for 8 edges, all entries 0 afterward; second rf_clear pulse mid-sweep extends busy to 8 edges from restart.
- Async reset asserted mid-sweep (clr_addr=4) -> rf_busy stays 1, sweep restarts from 0, busy drops 8 edges after release; repeat with ADDR_BITS=1, WIDTH=1 -> 2-cycle sweep.
